multicycle_ctrl: RTL

Parametrised FSM control unit for the multi-cycle MIPS datapath; successor to the single-cycle opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, drives all datapath strobes and muxes, and handshakes with a variable-latency memory. Adds a memory-timeout watchdog, illegal-opcode reporting and an optional jump path.

---
 rtl/multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : FSM control unit for the multi-cycle MIPS datapath. Sequences
//            FETCH/DECODE/EXEC/ADDR/MEM/WB/BRANCH/JUMP, drives all datapath
//            strobes and mux selects, handshakes with variable-latency memory,
//            runs a memory-wait watchdog and flags illegal opcodes.
// Config   : define JUMP_EN to decode opcode 000010 (j) into the JUMP state;
//            when undefined, j is reported as illegal and PCSource never 10.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    output logic                PCWrite_o,
    output logic                PCWriteCond_o,
    output logic                IorD_o,
    output logic                MemRead_o,
    output logic                MemWrite_o,
    output logic                IRWrite_o,
    output logic                MemtoReg_o,
    output logic                RegDst_o,
    output logic                RegWrite_o,
    output logic                ALUSrcA_o,
    output logic [1:0]          ALUSrcB_o,
    output logic [ALU_OP_W-1:0] ALU_op_o,
    output logic [1:0]          PCSource_o,
    output logic [2:0]          state_o,
    output logic                illegal_o,
    output logic                timeout_o
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_ADDR   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_BRANCH = 3'd6;
    localparam logic [2:0] c_ST_JUMP   = 3'd7;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_FUNCT = 3'b010;
    localparam logic [2:0] c_ALU_AND   = 3'b011;
    localparam logic [2:0] c_ALU_SLT   = 3'b100;

    localparam logic [1:0] c_SRCB_REGB  = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
`ifdef JUMP_EN
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
`endif

    // Wait counter must hold the value MEM_TIMEOUT; keep at least one bit
    // so the vector stays legal when the watchdog is disabled.
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_WD_LAST =
        CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [5:0]       r_op;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;

    logic [2:0]       w_state_nxt;
    logic             w_op_supported;
    logic             w_waiting;
    logic             w_wd_fire;

    logic             w_pcwrite;
    logic             w_pcwritecond;
    logic             w_iord;
    logic             w_memread;
    logic             w_memwrite;
    logic             w_irwrite;
    logic             w_memtoreg;
    logic             w_regdst;
    logic             w_regwrite;
    logic             w_alusrca;
    logic [1:0]       w_alusrcb;
    logic [2:0]       w_alu_op;
    logic [1:0]       w_pcsource;
    logic             w_illegal;

    // A memory wait cycle is any FETCH/MEM cycle where the access has not
    // completed; the watchdog fires on the MEM_TIMEOUT-th such cycle unless
    // ready arrives in that same cycle.
    assign w_waiting = ((r_state == c_ST_FETCH) || (r_state == c_ST_MEM)) && !mem_ready_i;
    assign w_wd_fire = (MEM_TIMEOUT != 0) && w_waiting && (r_wait_cnt == c_WD_LAST);

    // Opcodes this controller knows how to sequence.
    always_comb begin
        case (instr_op_i)
            c_OP_RTYPE, c_OP_ADDI, c_OP_ANDI, c_OP_SLTI,
            c_OP_LW, c_OP_SW, c_OP_BEQ: w_op_supported = 1'b1;
`ifdef JUMP_EN
            c_OP_J:                      w_op_supported = 1'b1;
`endif
            default:                     w_op_supported = 1'b0;
        endcase
    end

    // State register, latched opcode, watchdog counter and sticky timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_FETCH;
            r_op       <= 6'b000000;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_DECODE) begin
                r_op <= instr_op_i;
            end
            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
            // Counter restarts whenever a state is (re-)entered.
            if ((w_state_nxt != r_state) || w_wd_fire) begin
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state sequencing; a watchdog expiry overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_FETCH: begin
                if (mem_ready_i) begin
                    w_state_nxt = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                case (instr_op_i)
                    c_OP_RTYPE, c_OP_ADDI,
                    c_OP_ANDI, c_OP_SLTI: w_state_nxt = c_ST_EXEC;
                    c_OP_LW, c_OP_SW:     w_state_nxt = c_ST_ADDR;
                    c_OP_BEQ:             w_state_nxt = c_ST_BRANCH;
`ifdef JUMP_EN
                    c_OP_J:               w_state_nxt = c_ST_JUMP;
`endif
                    default:              w_state_nxt = c_ST_FETCH;
                endcase
            end
            c_ST_EXEC:   w_state_nxt = c_ST_WB;
            c_ST_ADDR:   w_state_nxt = c_ST_MEM;
            c_ST_MEM: begin
                if (mem_ready_i) begin
                    w_state_nxt = (r_op == c_OP_LW) ? c_ST_WB : c_ST_FETCH;
                end
            end
            c_ST_WB:     w_state_nxt = c_ST_FETCH;
            c_ST_BRANCH: w_state_nxt = c_ST_FETCH;
            c_ST_JUMP:   w_state_nxt = c_ST_FETCH;
            default:     w_state_nxt = c_ST_FETCH;
        endcase
        if (w_wd_fire) begin
            w_state_nxt = c_ST_FETCH;
        end
    end

    // Datapath strobes and mux selects decoded from state and latched opcode.
    always_comb begin
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_regwrite    = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = c_SRCB_REGB;
        w_alu_op      = c_ALU_ADD;
        w_pcsource    = c_PCSRC_ALU;
        w_illegal     = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                // PC+4 computed in parallel with the instruction read.
                w_memread = 1'b1;
                w_alusrcb = c_SRCB_FOUR;
                w_irwrite = mem_ready_i;
                w_pcwrite = mem_ready_i;
            end
            c_ST_DECODE: begin
                // Speculative branch target PC + (imm << 2).
                w_alusrcb = c_SRCB_IMMSH;
                w_illegal = !w_op_supported;
            end
            c_ST_EXEC: begin
                w_alusrca = 1'b1;
                if (r_op == c_OP_RTYPE) begin
                    w_alusrcb = c_SRCB_REGB;
                    w_alu_op  = c_ALU_FUNCT;
                end else begin
                    w_alusrcb = c_SRCB_IMM;
                    case (r_op)
                        c_OP_ANDI: w_alu_op = c_ALU_AND;
                        c_OP_SLTI: w_alu_op = c_ALU_SLT;
                        default:   w_alu_op = c_ALU_ADD;
                    endcase
                end
            end
            c_ST_ADDR: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_SRCB_IMM;
            end
            c_ST_MEM: begin
                w_iord     = 1'b1;
                w_memread  = (r_op == c_OP_LW);
                w_memwrite = (r_op == c_OP_SW);
            end
            c_ST_WB: begin
                w_regwrite = 1'b1;
                w_regdst   = (r_op == c_OP_RTYPE);
                w_memtoreg = (r_op == c_OP_LW);
            end
            c_ST_BRANCH: begin
                w_alusrca     = 1'b1;
                w_alusrcb     = c_SRCB_REGB;
                w_alu_op      = c_ALU_SUB;
                w_pcwritecond = 1'b1;
                w_pcsource    = c_PCSRC_ALUOUT;
            end
            c_ST_JUMP: begin
`ifdef JUMP_EN
                w_pcwrite  = 1'b1;
                w_pcsource = c_PCSRC_JUMP;
`endif
            end
            default: begin
                w_pcwrite = 1'b0;
            end
        endcase
    end

    // Architectural write strobes are suppressed while reset is asserted so
    // an instruction interrupted by reset cannot commit partial state.
    assign PCWrite_o     = w_pcwrite     & ~rst_i;
    assign PCWriteCond_o = w_pcwritecond & ~rst_i;
    assign MemRead_o     = w_memread     & ~rst_i;
    assign MemWrite_o    = w_memwrite    & ~rst_i;
    assign IRWrite_o     = w_irwrite     & ~rst_i;
    assign RegWrite_o    = w_regwrite    & ~rst_i;

    assign IorD_o        = w_iord;
    assign MemtoReg_o    = w_memtoreg;
    assign RegDst_o      = w_regdst;
    assign ALUSrcA_o     = w_alusrca;
    assign ALUSrcB_o     = w_alusrcb;
    assign ALU_op_o      = ALU_OP_W'(w_alu_op);
    assign PCSource_o    = w_pcsource;
    assign state_o       = r_state;
    assign illegal_o     = w_illegal;
    assign timeout_o     = r_timeout;

endmodule
`default_nettype wire
